// File: rtl/imem_pkg.sv
// imem_pkg -- shared types and constants for the instruction-memory responder.
//   state_t     : responder FSM states (IDLE, WAIT)
//   NOP         : RISC-V "addi x0,x0,0", the default out-of-range fetch data
//   WAIT_CNT_W  : width of the wait-state counter / wait_cycles port
//   idx_width() : word-index width needed for a given array depth
package imem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam int          WAIT_CNT_W = 4;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_bus.sv
// instr_bus -- simple single-beat instruction fetch bus.
//   req    : master requests a fetch this cycle
//   addr   : byte address of the fetch
//   rvalid : slave returns a word this cycle
//   rdata  : returned instruction word
interface instr_bus;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;

    modport slave  (input  req, addr, output rvalid, rdata);
    modport master (output req, addr, input  rvalid, rdata);
endinterface

// File: rtl/imem_array.sv
// imem_array -- DEPTH_WORDS x 32 storage, one synchronous read port and one
// synchronous write port. A read and a write to the same word in the same
// cycle return the old contents (read-first).
//   clk, rst_n : clock, async active-low reset (read register only)
//   rd_en      : load the read register from mem[rd_idx]
//   rd_idx     : read word index
//   wr_en      : write wr_data to mem[wr_idx]
//   wr_idx     : write word index
//   wr_data    : write data
//   rd_data    : registered read data, holds when rd_en is low
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = idx_width(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_d, rd_data_q;

    // Contents are deliberately not reset; preload provides initial state.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= 32'h0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// imem_responder -- instruction memory slave with preload port.
// A fetch accepted in cycle T returns its word in T+1 (T+1+W with wait
// states). Out-of-range fetches return OOR_INSTR with a one-cycle oor_err.
// Optional feature macro: IMEM_WAIT_STATES_EN adds the wait_cycles port and
// a WAIT state holding the response for W cycles.
//   clk, rst_n  : clock, async active-low reset
//   ibus        : instr_bus slave (req/addr in, rvalid/rdata out)
//   ld_en       : preload write strobe
//   ld_addr     : preload byte address (out-of-range writes are dropped)
//   ld_data     : preload word
//   oor_err     : pulses with rvalid when the served fetch was out of range
//   wait_cycles : wait states per fetch, sampled at accept (macro only)
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] OOR_INSTR   = NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    instr_bus.slave     ibus,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        oor_err
`ifdef IMEM_WAIT_STATES_EN
    ,
    input  logic [WAIT_CNT_W-1:0] wait_cycles
`endif
);

    localparam int AW = idx_width(DEPTH_WORDS);

    // Byte-offset bits are ignored on both ports.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{ibus.addr[1:0], ld_addr[1:0]};

    logic [29:0] fetch_idx;
    logic        fetch_oor;
    assign fetch_idx = ibus.addr[31:2];
    assign fetch_oor = {2'b00, fetch_idx} >= 32'(DEPTH_WORDS);

    logic wr_en;
    assign wr_en = ld_en && ({2'b00, ld_addr[31:2]} < 32'(DEPTH_WORDS));

    // Response control, produced by the accept logic below.
    logic          rd_en;
    logic [AW-1:0] rd_idx;
    logic          resp_fire;
    logic          resp_oor;

    logic rvalid_d,   rvalid_q;
    logic oor_err_d,  oor_err_q;
    logic last_oor_d, last_oor_q;

`ifdef IMEM_WAIT_STATES_EN
    state_t                state_d, state_q;
    logic [WAIT_CNT_W-1:0] cnt_d, cnt_q;
    logic [AW-1:0]         idx_d, idx_q;
    logic                  pend_oor_d, pend_oor_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pend_oor_d = pend_oor_q;
        rd_en      = 1'b0;
        rd_idx     = fetch_idx[AW-1:0];
        resp_fire  = 1'b0;
        resp_oor   = fetch_oor;
        unique case (state_q)
            IDLE: begin
                if (ibus.req) begin
                    if (wait_cycles == '0) begin
                        resp_fire = 1'b1;
                        rd_en     = !fetch_oor;
                    end else begin
                        state_d    = WAIT;
                        cnt_d      = wait_cycles;
                        idx_d      = fetch_idx[AW-1:0];
                        pend_oor_d = fetch_oor;
                    end
                end
            end
            WAIT: begin
                // req is ignored here. The array is read in the last WAIT
                // cycle so rdata reflects the word at response time.
                rd_idx   = idx_q;
                resp_oor = pend_oor_q;
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                if (cnt_q == WAIT_CNT_W'(1)) begin
                    state_d   = IDLE;
                    resp_fire = 1'b1;
                    rd_en     = !pend_oor_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_oor_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_oor_q <= pend_oor_d;
        end
    end
`else
    always_comb begin
        resp_fire = ibus.req;
        resp_oor  = fetch_oor;
        rd_en     = ibus.req && !fetch_oor;
        rd_idx    = fetch_idx[AW-1:0];
    end
`endif

    // last_oor_q selects the rdata source and only changes on a response,
    // so rdata holds its last value between responses.
    always_comb begin
        rvalid_d   = resp_fire;
        oor_err_d  = resp_fire && resp_oor;
        last_oor_d = resp_fire ? resp_oor : last_oor_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q   <= 1'b0;
            oor_err_q  <= 1'b0;
            last_oor_q <= 1'b0;
        end else begin
            rvalid_q   <= rvalid_d;
            oor_err_q  <= oor_err_d;
            last_oor_q <= last_oor_d;
        end
    end

    logic [31:0] arr_rdata;

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .wr_en   (wr_en),
        .wr_idx  (ld_addr[AW+1:2]),
        .wr_data (ld_data),
        .rd_data (arr_rdata)
    );

    assign ibus.rvalid = rvalid_q;
    assign ibus.rdata  = last_oor_q ? OOR_INSTR : arr_rdata;
    assign oor_err     = oor_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder -- directed, table-driven bench for imem_responder.
// Each table row is applied for one cycle; outputs are sampled 1ns after the
// following rising edge. Multi-cycle cases (reset, wait states) are written
// out by hand below the table loop.
module tb_imem_responder;

    logic        clk;
    logic        rst_n;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        oor_err;
`ifdef IMEM_WAIT_STATES_EN
    logic [3:0]  wait_cycles;
`endif

    instr_bus bus ();

    imem_responder #(
        .DEPTH_WORDS (1024),
        .OOR_INSTR   (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ibus        (bus),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .oor_err     (oor_err)
`ifdef IMEM_WAIT_STATES_EN
        ,
        .wait_cycles (wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld_en;
        logic [31:0] ld_addr;
        logic [31:0] ld_data;
        logic        req;
        logic [31:0] addr;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic        exp_oor;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic l, input logic [31:0] la, input logic [31:0] ld,
                                input logic r, input logic [31:0] a,
                                input logic ev, input logic [31:0] ed, input logic eo);
        vec_t v;
        v.ld_en = l;  v.ld_addr = la; v.ld_data = ld;
        v.req = r;    v.addr = a;
        v.exp_rvalid = ev; v.exp_rdata = ed; v.exp_oor = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic ev, input logic [31:0] ed, input logic eo);
        chk({name, ".rvalid"},  32'(bus.rvalid), 32'(ev));
        chk({name, ".rdata"},   bus.rdata,       ed);
        chk({name, ".oor_err"}, 32'(oor_err),    32'(eo));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_en    = 1'b0;
        ld_addr  = 32'h0;
        ld_data  = 32'h0;
        bus.req  = 1'b0;
        bus.addr = 32'h0;
`ifdef IMEM_WAIT_STATES_EN
        wait_cycles = 4'd0;
`endif
    endtask

    initial begin
        // ld_en ld_addr ld_data  req addr    -> rvalid rdata  oor
        vecs[0]  = mk(1, 32'h0,   32'hA0,   0, 32'h0,         0, 32'h0,  0);
        vecs[1]  = mk(1, 32'h4,   32'hA1,   0, 32'h0,         0, 32'h0,  0);
        vecs[2]  = mk(1, 32'h8,   32'hA2,   0, 32'h0,         0, 32'h0,  0);
        vecs[3]  = mk(1, 32'hC,   32'hA3,   0, 32'h0,         0, 32'h0,  0);
        // back-to-back fetches, one response per cycle
        vecs[4]  = mk(0, 32'h0,   32'h0,    1, 32'h0,         1, 32'hA0, 0);
        vecs[5]  = mk(0, 32'h0,   32'h0,    1, 32'h4,         1, 32'hA1, 0);
        vecs[6]  = mk(0, 32'h0,   32'h0,    1, 32'h8,         1, 32'hA2, 0);
        vecs[7]  = mk(0, 32'h0,   32'h0,    1, 32'hC,         1, 32'hA3, 0);
        vecs[8]  = mk(0, 32'h0,   32'h0,    0, 32'h0,         0, 32'hA3, 0);
        // out-of-range fetch, then rdata holds the NOP
        vecs[9]  = mk(0, 32'h0,   32'h0,    1, 32'h1000,      1, 32'h13, 1);
        vecs[10] = mk(0, 32'h0,   32'h0,    0, 32'h0,         0, 32'h13, 0);
        // unaligned fetch maps to word 1
        vecs[11] = mk(0, 32'h0,   32'h0,    1, 32'h6,         1, 32'hA1, 0);
        // read-first collision, then the new word
        vecs[12] = mk(1, 32'h4,   32'h55,   1, 32'h4,         1, 32'hA1, 0);
        vecs[13] = mk(0, 32'h0,   32'h0,    1, 32'h4,         1, 32'h55, 0);
        // out-of-range load (would alias word 0 if not dropped)
        vecs[14] = mk(1, 32'h1000,32'hDEAD, 1, 32'h0,         1, 32'hA0, 0);
        vecs[15] = mk(0, 32'h0,   32'h0,    1, 32'h0,         1, 32'hA0, 0);
        // last in-range word
        vecs[16] = mk(1, 32'hFFC, 32'h77,   0, 32'h0,         0, 32'hA0, 0);
        vecs[17] = mk(0, 32'h0,   32'h0,    1, 32'hFFC,       1, 32'h77, 0);
        vecs[18] = mk(0, 32'h0,   32'h0,    1, 32'hFFFF_FFFF, 1, 32'h13, 1);
        // unaligned load address maps to word 1
        vecs[19] = mk(1, 32'h7,   32'h66,   0, 32'h0,         0, 32'h13, 0);
        vecs[20] = mk(0, 32'h0,   32'h0,    1, 32'h4,         1, 32'h66, 0);

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < NVEC; i++) begin
            ld_en    = vecs[i].ld_en;
            ld_addr  = vecs[i].ld_addr;
            ld_data  = vecs[i].ld_data;
            bus.req  = vecs[i].req;
            bus.addr = vecs[i].addr;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_rvalid, vecs[i].exp_rdata, vecs[i].exp_oor);
        end
        idle_inputs();
        tick();

        // Reset while a response is on the bus: cleared at once, nothing follows.
        bus.req  = 1'b1;
        bus.addr = 32'h8;
        tick();
        bus.req = 1'b0;
        chk_out("pre_rst", 1'b1, 32'hA2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 1'b0);
        tick();
        chk_out("in_rst", 1'b0, 32'h0, 1'b0);
        // Accept on the first edge after release; memory survived reset.
        @(negedge clk);
        rst_n    = 1'b1;
        bus.req  = 1'b1;
        bus.addr = 32'h8;
        tick();
        bus.req = 1'b0;
        chk_out("first_after_rst", 1'b1, 32'hA2, 1'b0);
        tick();
        chk_out("idle_after_rst", 1'b0, 32'hA2, 1'b0);

`ifdef IMEM_WAIT_STATES_EN
        // W=3 fetch of word 2; redirect to 0x40 must not change it.
        bus.req     = 1'b1;
        bus.addr    = 32'h8;
        wait_cycles = 4'd3;
        tick();
        bus.addr = 32'h40;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("w3_T%0d.rvalid", k), 32'(bus.rvalid), 32'h0);
            tick();
        end
        chk_out("w3_T4", 1'b1, 32'hA2, 1'b0);
        // Next accept in the rvalid cycle, W=0.
        bus.addr    = 32'h0;
        wait_cycles = 4'd0;
        tick();
        bus.req = 1'b0;
        chk_out("w3_next", 1'b1, 32'hA0, 1'b0);
        tick();
        chk_out("w3_idle", 1'b0, 32'hA0, 1'b0);

        // W=1 out-of-range fetch.
        bus.req     = 1'b1;
        bus.addr    = 32'h2000;
        wait_cycles = 4'd1;
        tick();
        bus.req = 1'b0;
        chk("w1_oor_T1.rvalid", 32'(bus.rvalid), 32'h0);
        tick();
        chk_out("w1_oor_T2", 1'b1, 32'h13, 1'b1);

        // W=5 fetch killed by reset at T+2.
        bus.req     = 1'b1;
        bus.addr    = 32'h4;
        wait_cycles = 4'd5;
        tick();
        bus.req = 1'b0;
        chk("w5_T1.rvalid", 32'(bus.rvalid), 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        chk_out("w5_rst", 1'b0, 32'h0, 1'b0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_out($sformatf("w5_post%0d", k), 1'b0, 32'h0, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
